// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-memory handshake with big-endian
// lane steering, load extension and the MEM/WB register feeding writeback.
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [0:31] aluResult,
  input  logic [0:31] storeData,
  input  logic [0:31] nextPC,
  input  logic [0:4]  destReg,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic        MemWrite,
  input  logic        loadSign,
  input  logic        PCtoReg,
  input  logic [0:1]  DSize,
  output logic [0:31] dmem_addr,
  output logic [0:31] dmem_wdata,
  output logic [0:3]  dmem_be,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic [0:31] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic [0:31] wb_data,
  output logic [0:4]  wb_destReg,
  output logic        mem_error
);

  localparam int CNT_W = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  typedef struct packed {
    logic [0:31] alu;
    logic [0:31] sd;
    logic [0:31] npc;
    logic [0:4]  dest;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        loadsign;
    logic        pctoreg;
    logic [0:1]  dsize;
  } exm_t;

  // lo is address bits [30:31]; lane 0 is the lowest address (bits [0:7]).
  function automatic logic is_misaligned(input logic [0:1] dsize, input logic [0:1] lo);
    case (dsize)
      2'b00:   return 1'b0;
      2'b01:   return lo[1];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [0:3] lane_be(input logic [0:1] dsize, input logic [0:1] lo);
    case (dsize)
      2'b00:   return 4'b1000 >> lo;
      2'b01:   return lo[0] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [0:31] store_lanes(input logic [0:1] dsize, input logic [0:31] d);
    case (dsize)
      2'b00:   return {4{d[24:31]}};
      2'b01:   return {2{d[16:31]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [0:31] load_extract(input logic [0:1] dsize, input logic [0:1] lo,
                                               input logic [0:31] rd, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rd[0:7];
      2'd1:    b = rd[8:15];
      2'd2:    b = rd[16:23];
      default: b = rd[24:31];
    endcase
    h = lo[0] ? rd[16:31] : rd[0:15];
    case (dsize)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exm_valid_q, exm_valid_d;
  exm_t             exm_q, exm_d;
  logic             wb_valid_q, wb_valid_d;
  logic             wb_regwrite_q, wb_regwrite_d;
  logic [0:31]      wb_data_q, wb_data_d;
  logic [0:4]       wb_dest_q, wb_dest_d;

  logic in_access, abort, misal, new_access, retire;

  assign in_access  = (state_q == ACCESS);
  assign abort      = in_access & !dmem_ready & (cnt_q == CNT_LAST);
  assign mem_stall  = in_access & !dmem_ready & !abort;
  assign misal      = exm_valid_q & (exm_q.memtoreg | exm_q.memwrite)
                    & is_misaligned(exm_q.dsize, exm_q.alu[30:31]);
  assign new_access = !mem_stall & ex_valid & (MemToReg | MemWrite)
                    & !is_misaligned(DSize, aluResult[30:31]);
  assign retire     = !mem_stall & exm_valid_q & !misal & !abort;
  assign mem_error  = misal | abort;

  // Request fields are gated so they read zero whenever no access is in flight.
  assign dmem_req   = in_access;
  assign dmem_we    = in_access & exm_q.memwrite;
  assign dmem_addr  = in_access ? {exm_q.alu[0:29], 2'b00} : '0;
  assign dmem_wdata = in_access ? store_lanes(exm_q.dsize, exm_q.sd) : '0;
  assign dmem_be    = in_access ? lane_be(exm_q.dsize, exm_q.alu[30:31]) : '0;

  assign wb_valid    = wb_valid_q;
  assign wb_RegWrite = wb_regwrite_q;
  assign wb_data     = wb_data_q;
  assign wb_destReg  = wb_dest_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exm_valid_d = exm_valid_q;
    exm_d       = exm_q;
    if (!mem_stall) begin
      exm_valid_d = ex_valid;
      exm_d       = '{alu: aluResult, sd: storeData, npc: nextPC, dest: destReg,
                      regwrite: RegWrite, memtoreg: MemToReg, memwrite: MemWrite,
                      loadsign: loadSign, pctoreg: PCtoReg, dsize: DSize};
    end
    case (state_q)
      IDLE: begin
        if (new_access) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      default: begin
        if (dmem_ready | abort) begin
          state_d = new_access ? ACCESS : IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    wb_valid_d    = retire;
    wb_regwrite_d = retire & exm_q.regwrite;
    wb_data_d     = wb_data_q;
    wb_dest_d     = wb_dest_q;
    if (retire) begin
      wb_dest_d = exm_q.dest;
      if (exm_q.pctoreg)
        wb_data_d = exm_q.npc;
      else if (exm_q.memtoreg)
        wb_data_d = load_extract(exm_q.dsize, exm_q.alu[30:31], dmem_rdata, exm_q.loadsign);
      else
        wb_data_d = exm_q.alu;
    end
  end

  // EX/MEM and MEM/WB stage boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      exm_valid_q   <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_data_q     <= '0;
      wb_dest_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      exm_valid_q   <= exm_valid_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_data_q     <= wb_data_d;
      wb_dest_q     <= wb_dest_d;
    end
  end

  always_ff @(posedge clk) begin
    exm_q <= exm_d;
  end

endmodule
